// File: rtl/crypt_pkg.sv
// Shared definitions for the stream cipher pair (encryptor / decryptor).
package crypt_pkg;

  typedef logic [7:0] byte_t;

  // Secret key material, "K3yS3cr".
  localparam int SECRET_LEN   = 7;
  localparam int SECRET_IDX_W = $clog2(SECRET_LEN);
  localparam byte_t SECRET [0:SECRET_LEN-1] = '{
    8'h4B, 8'h33, 8'h79, 8'h53, 8'h33, 8'h63, 8'h72
  };

  // Undo the position offset first, then the key XOR.
  function automatic byte_t dec_byte(input byte_t c, input byte_t i, input byte_t key);
    byte_t t;
    t = c - i;
    return t ^ key;
  endfunction

  // Forward cipher: key XOR, then add the position offset (mod 256).
  function automatic byte_t enc_byte(input byte_t p, input byte_t i, input byte_t key);
    byte_t t;
    t = p ^ key;
    return t + i;
  endfunction

endpackage

// File: rtl/key_index_ctr.sv
// Key index counter: walks 0..SEC_LEN-1 and wraps, with a clear that wins over step.
module key_index_ctr #(
  parameter int SEC_LEN = 7,
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clear,
  output logic [KW-1:0] k
);

  localparam logic [KW-1:0] K_MAX = KW'(SEC_LEN - 1);

  logic [KW-1:0] k_reg;

  // Advance on step, wrap at the last key byte, return to 0 on clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg <= '0;
    end else if (clear) begin
      k_reg <= '0;
    end else if (step) begin
      k_reg <= (k_reg == K_MAX) ? '0 : k_reg + 1'b1;
    end
  end

  assign k = k_reg;

endmodule

// File: rtl/stream_decryptor.sv
// Byte-serial, frame-aware decryptor with a single registered output stage.
module stream_decryptor
  import crypt_pkg::*;
#(
  parameter int MSG_LEN = 16,
  parameter int SEC_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_err,
  output logic       busy
);

  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
  localparam logic [IW-1:0] I_MAX = IW'(MSG_LEN - 1);

  typedef enum logic {IDLE, RUN} dec_state_t;

  dec_state_t    state_reg, state_next;
  logic [IW-1:0] i_reg;
  logic [KW-1:0] k_val;

  logic       out_valid_reg;
  byte_t      out_data_reg;
  logic       out_last_reg;
  logic       frame_err_reg;

  logic       accept;
  logic       at_max;
  logic       end_msg;
  logic       err_next;
  byte_t      i_byte;
  byte_t      key;
  byte_t      plain;
  logic       busy_next;

  // The output register can take a new byte whenever it is empty or draining.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // A message closes on whichever comes first: the sender's last flag or the final index.
  assign at_max   = (i_reg == I_MAX);
  assign end_msg  = in_last || at_max;
  assign err_next = accept && end_msg && (in_last != at_max);

  // Offset uses only the low byte of the index, so it wraps modulo 256.
  assign i_byte = 8'(i_reg);
  assign key    = SECRET[SECRET_IDX_W'(k_val)];
  assign plain  = dec_byte(in_data, i_byte, key);

  key_index_ctr #(
    .SEC_LEN (SEC_LEN)
  ) u_key_index_ctr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .clear (accept && end_msg),
    .k     (k_val)
  );

  // Byte index within the message: advances per accept, clears at message end.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_reg <= '0;
    end else if (accept) begin
      i_reg <= end_msg ? '0 : i_reg + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: enter RUN on a non-final first byte, leave on the final byte.
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && !end_msg) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy_next = 1'b1;
        if (accept && end_msg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_next;

  // Output stage: load on accept, drop valid after a drain with no new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= plain;
      out_last_reg  <= end_msg;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Framing error is a single-cycle pulse tied to the offending byte's load.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_stream_decryptor.sv
// Directed bench for stream_decryptor across several message lengths.
module tb_stream_decryptor;

  localparam int NDUT = 5;
  localparam int ML [NDUT] = '{1, 2, 16, 4, 8};

  localparam logic [7:0] TB_KEY [0:6] = '{8'h4B, 8'h33, 8'h79, 8'h53, 8'h33, 8'h63, 8'h72};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_data_last;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_valid  [NDUT];
  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic [7:0] out_data  [NDUT];
  logic       out_last  [NDUT];
  logic       frame_err [NDUT];
  logic       busy      [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    stream_decryptor #(
      .MSG_LEN (ML[gi]),
      .SEC_LEN (7)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready),
      .out_data  (out_data[gi]),
      .out_last  (out_last[gi]),
      .frame_err (frame_err[gi]),
      .busy      (busy[gi])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encryptor, independent of the design package.
  function automatic logic [7:0] tb_enc(input logic [7:0] p, input int i);
    logic [7:0] t;
    t = p ^ TB_KEY[i % 7];
    return t + 8'(i);
  endfunction

  // One byte through DUT d with out_ready high; checks the registered result next cycle.
  task automatic xfer(input int d, input logic [7:0] c, input logic last,
                      input logic [7:0] exp_p, input logic exp_last,
                      input logic exp_err, input logic exp_busy, input string tag);
    in_valid[d] = 1'b1;
    in_data     = c;
    in_last     = last;
    #1;
    check_eq({tag, "_in_ready"}, in_ready[d], 1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_last     = 1'b0;
    #1;
    $display("xfer dut%0d c=%02h last=%0b -> valid=%0b p=%02h out_last=%0b err=%0b busy=%0b",
             d, c, last, out_valid[d], out_data[d], out_last[d], frame_err[d], busy[d]);
    check_eq({tag, "_valid"}, out_valid[d], 1);
    check_eq({tag, "_data"},  out_data[d],  exp_p);
    check_eq({tag, "_last"},  out_last[d],  exp_last);
    check_eq({tag, "_ferr"},  frame_err[d], exp_err);
    check_eq({tag, "_busy"},  busy[d],      exp_busy);
  endtask

  initial begin
    string      hs;
    string      hello;
    string      test4;
    int         sent;
    int         got;
    logic       acc;
    logic       held;
    logic [7:0] held_data;

    hs    = "HardwareSecurity";
    hello = "Hello!";
    test4 = "Test";
    in_data_last = 1'b0;
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("rst_valid%0d", d), out_valid[d], 0);
      check_eq($sformatf("rst_data%0d", d),  out_data[d],  0);
      check_eq($sformatf("rst_last%0d", d),  out_last[d],  0);
      check_eq($sformatf("rst_ferr%0d", d),  frame_err[d], 0);
      check_eq($sformatf("rst_busy%0d", d),  busy[d],      0);
      check_eq($sformatf("rst_rdy%0d", d),   in_ready[d],  1);
    end

    // MSG_LEN=1: single-byte message, busy never rises
    xfer(0, 8'h03, 1'b1, 8'h48, 1'b1, 1'b0, 1'b0, "t1");
    @(negedge clk); #1;
    check_eq("t1_drained", out_valid[0], 0);
    check_eq("t1_ferr_after", frame_err[0], 0);

    // MSG_LEN=2: "Hi" back to back
    xfer(1, 8'h03, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1, "t2a");
    xfer(1, 8'h5B, 1'b1, 8'h69, 1'b1, 1'b0, 1'b0, "t2b");
    @(negedge clk); #1;
    check_eq("t2_drained", out_valid[1], 0);

    // MSG_LEN=16: full message with out_ready toggling
    sent = 0; got = 0; held = 1'b0; held_data = 8'h00;
    in_data = tb_enc(8'(hs[0]), 0); in_last = 1'b0; in_valid[2] = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      out_ready = (cyc % 2 == 0);
      #1;
      acc = in_valid[2] && in_ready[2];
      if (held) begin
        check_eq("t3_hold_valid", out_valid[2], 1);
        check_eq("t3_hold_data", out_data[2], held_data);
      end
      held = 1'b0;
      check_eq("t3_ferr", frame_err[2], 0);
      if (out_valid[2] && out_ready) begin
        $display("t3 byte %0d p=%02h last=%0b", got, out_data[2], out_last[2]);
        check_eq($sformatf("t3_data%0d", got), out_data[2], 32'(hs[got]));
        check_eq($sformatf("t3_last%0d", got), out_last[2], (got == 15) ? 1 : 0);
        got++;
      end else if (out_valid[2]) begin
        check_eq("t3_stall_rdy", in_ready[2], 0);
        held      = 1'b1;
        held_data = out_data[2];
      end
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent < 16) begin
          in_data = tb_enc(8'(hs[sent]), sent);
          in_last = (sent == 15);
        end else begin
          in_valid[2] = 1'b0;
          in_last     = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    #1;
    check_eq("t3_sent", sent, 16);
    check_eq("t3_got", got, 16);
    check_eq("t3_idle_valid", out_valid[2], 0);
    check_eq("t3_idle_busy", busy[2], 0);

    // MSG_LEN=16, early last on byte 5
    for (int j = 0; j < 6; j++) begin
      xfer(2, tb_enc(8'(hello[j]), j), (j == 5), 8'(hello[j]), (j == 5), (j == 5), (j != 5),
           $sformatf("t4_%0d", j));
    end
    xfer(2, 8'h03, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1, "t4_restart");

    // MSG_LEN=4, missing last on byte 3
    for (int j = 0; j < 4; j++) begin
      xfer(3, tb_enc(8'(test4[j]), j), 1'b0, 8'(test4[j]), (j == 3), (j == 3), (j != 3),
           $sformatf("t5_%0d", j));
    end
    xfer(3, 8'h03, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1, "t5_restart");

    // MSG_LEN=8, reset while a byte is held
    xfer(4, tb_enc(8'h48, 0), 1'b0, 8'h48, 1'b0, 1'b0, 1'b1, "t6_0");
    xfer(4, tb_enc(8'h69, 1), 1'b0, 8'h69, 1'b0, 1'b0, 1'b1, "t6_1");
    xfer(4, tb_enc(8'h21, 2), 1'b0, 8'h21, 1'b0, 1'b0, 1'b1, "t6_2");
    out_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("t6_held_valid", out_valid[4], 1);
    check_eq("t6_held_data", out_data[4], 8'h21);
    check_eq("t6_held_rdy", in_ready[4], 0);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("t6_rst_valid", out_valid[4], 0);
    check_eq("t6_rst_busy", busy[4], 0);
    rst = 1'b0;
    out_ready = 1'b1;
    xfer(4, 8'h03, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1, "t6_after");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_decryptor.md
# stream_decryptor

Byte-serial, frame-aware decryptor that inverts the team's stream cipher one byte per accepted beat. It sits on the receive side of the link, after `stream_encryptor` and the channel. It takes ciphertext bytes under a valid/ready handshake, removes the per-position key and offset, and presents plaintext under valid/ready with message framing. Message length and key length are parameters shared with the encryptor.

## Interface
- `MSG_LEN`, default 16: bytes per message, must be ≥1.
- `SEC_LEN`, default 7: secret length in bytes, must be ≥1 and ≤ length of `crypt_pkg::SECRET`.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ciphertext byte present.
- `in_ready`  out  1  block accepts the byte this cycle.
- `in_data`  in  8  ciphertext byte.
- `in_last`  in  1  sender marks final byte of message.
- `out_valid`  out  1  plaintext byte present.
- `out_ready`  in  1  sink accepts the byte.
- `out_data`  out  8  plaintext byte.
- `out_last`  out  1  final byte of the message.
- `frame_err`  out  1  one-cycle pulse on framing violation.
- `busy`  out  1  a message is partially received (state RUN).

## Operation
- Cipher, per message, for byte index i (0-based) and k = i mod SEC_LEN:
  - encryptor: c = (p XOR SECRET[k]) + i[7:0], mod 256;
  - decryptor: p = (c − i[7:0]) XOR SECRET[k], mod 256.
- Counters:
  - i: width max(1,$clog2(MSG_LEN)). Adds only its low 8 bits, zero-extended, so the offset wraps past 255.
  - k: separate counter that wraps from SEC_LEN−1 to 0. No divider.
- Both counters advance only on an accept (`in_valid && in_ready`). Both clear to 0 at end of message.
- FSM:
  - IDLE → RUN on accept of byte 0 when it is not also the message end.
  - RUN → IDLE on accept of the end byte.
  - IDLE stays IDLE on a 1-byte message (MSG_LEN=1, or `in_last` on byte 0).
  - `busy` = (state == RUN).
- End of message is the first of these two events:
  - `in_last` accepted;
  - i == MSG_LEN−1 accepted.
- `out_last` is registered with that byte.
- `frame_err` pulses in the cycle after an end-byte accept if either:
  - `in_last` = 1 with i < MSG_LEN−1 (early last);
  - `in_last` = 0 with i == MSG_LEN−1 (missing last).
- A framing error is reported only. The message still closes, the byte is still delivered, and `out_last` = 1.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `frame_err` = 0, `busy` = 0;
  - state IDLE, i = 0, k = 0;
  - `in_ready` = 1 once `rst` is low.
- Reset mid-message drops any held output byte and the partial message. The next accepted byte is index 0.

## Timing
- Single output register stage. `in_ready` = !`out_valid` || `out_ready` (combinational from `out_ready`).
- Latency: byte accepted at edge N appears on `out_data` with `out_valid` high after edge N, i.e. in cycle N+1.
- Throughput: 1 byte/cycle with `out_ready` held high.
- Stall: while `out_valid && !out_ready`:
  - `out_data`/`out_last` are held stable;
  - `in_ready` = 0;
  - counters frozen.
- Simultaneous output drain and input accept in one cycle: register reloads with no bubble.
- `out_valid` falls only after a drain cycle with no new accept.
- `frame_err` is not held by a stall. It pulses exactly once, registered alongside the offending byte's load.

## Structure
- `crypt_pkg`, shared with `stream_encryptor`, holds:
  - `localparam byte SECRET[0:6]` = "K3yS3cr" (0x4B 0x33 0x79 0x53 0x33 0x63 0x72);
  - `typedef logic [7:0] byte_t`;
  - `function byte_t dec_byte(byte_t c, byte_t i, byte_t key)` and its inverse `enc_byte`.
- Sub-module `key_index_ctr`, also instantiated by the encryptor:
  - ports: clk, rst, step, clear, k out;
  - wraps at SEC_LEN−1.
- FSM type `typedef enum logic {IDLE, RUN} dec_state_t` stays local to the block.

## Test plan
- MSG_LEN=1, SEC_LEN=7, byte 0x03 with `in_last`=1 → next cycle `out_data` 0x48 ('H'), `out_last`=1, `frame_err`=0, `busy` stays 0.
- MSG_LEN=2, bytes 0x03 then 0x5B (last on 2nd), `out_ready`=1 → 0x48, 0x69 ("Hi") on back-to-back cycles, `out_last` only on 2nd, `busy` high for 1 cycle.
- MSG_LEN=16, 16 bytes from `enc_byte` of "HardwareSecurity", `out_ready` toggling 1/0 → exact plaintext, no loss or duplication, `out_data` stable while stalled, `in_ready`=0 during stall. Check k wrap 6→0 at i=7 and i=14.
- MSG_LEN=16, `in_last` on byte 5 → `frame_err` pulse with byte 5, `out_last`=1; next byte decrypts as i=0, k=0.
- MSG_LEN=4, no `in_last` on byte 3 → `frame_err` pulse, `out_last`=1, counters clear.
- `rst` asserted after byte 2 of a MSG_LEN=8 message with `out_valid` held (`out_ready`=0) → next cycle `out_valid`=0, `busy`=0; following 0x03 decrypts to 0x48.
